// File: rtl/hive_damage_writer_if.sv
// Hit-request handshake and hive sprite RAM write port used by hive_damage_writer.
interface hive_damage_writer_if;
    logic        hit_valid;
    logic        hit_ready;
    logic [5:0]  hit_x;
    logic [5:0]  hit_y;
    logic        wr_allow;
    logic [11:0] H_address;
    logic        H_write;
    logic [7:0]  H_data;
    logic        busy;
    logic        done;

    modport master (output hit_valid, hit_x, hit_y, wr_allow,
                    input  hit_ready, H_address, H_write, H_data, busy, done);
    modport slave  (input  hit_valid, hit_x, hit_y, wr_allow,
                    output hit_ready, H_address, H_write, H_data, busy, done);
endinterface

// File: rtl/hive_damage_writer.sv
// Erases a CRATER_W x CRATER_H crater of hive sprite RAM around a bullet hit.
// Optional feature: define HIVE_DMG_RAGGED_EN for an LFSR-thinned (ragged) crater.
module hive_damage_writer #(
    parameter int unsigned HIVE_W   = 56,
    parameter int unsigned HIVE_H   = 39,
    parameter int unsigned CRATER_W = 4,
    parameter int unsigned CRATER_H = 4,
    parameter logic [7:0]  TRANSP   = 8'h00
) (
    input logic           clk_pix,
    input logic           reset,
    hive_damage_writer_if.slave bus
);

    localparam int CXW = (CRATER_W > 1) ? $clog2(CRATER_W) : 1;
    localparam int CYW = (CRATER_H > 1) ? $clog2(CRATER_H) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CXW-1:0] cx_q, cx_d;
    logic [CYW-1:0] cy_q, cy_d;
    logic [6:0]     x0_q, x0_d, y0_q, y0_d;   // two's complement crater corner
    logic [11:0]    h_address_q, h_address_d;
    logic           h_write_q, h_write_d;
    logic [7:0]     h_data_q, h_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           hit_ready_q, hit_ready_d;

    logic        accept, hit_in_range, last_pos, pos_in_range, pos_write;
    logic [6:0]  px, py;
    logic [11:0] pos_addr;

    assign accept       = bus.hit_valid && hit_ready_q;
    assign hit_in_range = (32'(bus.hit_x) < HIVE_W) && (32'(bus.hit_y) < HIVE_H);
    assign last_pos     = (cx_q == CXW'(CRATER_W - 1)) && (cy_q == CYW'(CRATER_H - 1));

    assign px           = x0_q + 7'(cx_q);
    assign py           = y0_q + 7'(cy_q);
    assign pos_in_range = !px[6] && (32'(px[5:0]) < HIVE_W) &&
                          !py[6] && (32'(py[5:0]) < HIVE_H);
    assign pos_addr     = 12'(py[5:0]) * 12'(HIVE_W) + 12'(px[5:0]);

`ifdef HIVE_DMG_RAGGED_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        centre;

    assign centre    = (cx_q == CXW'(CRATER_W / 2)) && (cy_q == CYW'(CRATER_H / 2));
    assign pos_write = pos_in_range && (lfsr_q[0] || centre);

    // Galois LFSR, taps 16,14,13,11; steps once per consumed crater position.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == SCAN && bus.wr_allow)
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk_pix) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign pos_write = pos_in_range;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        h_address_d = h_address_q;
        h_write_d   = 1'b0;
        h_data_d    = TRANSP;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    x0_d    = {1'b0, bus.hit_x} - 7'(CRATER_W / 2);
                    y0_d    = {1'b0, bus.hit_y} - 7'(CRATER_H / 2);
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = hit_in_range ? SCAN : DONE;
                end
            end
            SCAN: begin
                // Clipped positions still consume their allowed cycle.
                if (bus.wr_allow) begin
                    if (pos_write) begin
                        h_write_d   = 1'b1;
                        h_address_d = pos_addr;
                    end
                    if (cx_q == CXW'(CRATER_W - 1)) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                    if (last_pos) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs trail the state by one register stage; accept drops ready at once.
        busy_d      = (state_q != IDLE) || accept;
        done_d      = (state_q == DONE);
        hit_ready_d = (state_q == IDLE) && !accept;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state_q     <= IDLE;
            cx_q        <= '0;
            cy_q        <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            h_address_q <= '0;
            h_write_q   <= 1'b0;
            h_data_q    <= TRANSP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            h_address_q <= h_address_d;
            h_write_q   <= h_write_d;
            h_data_q    <= h_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_ready_q <= hit_ready_d;
        end
    end

    assign bus.H_address = h_address_q;
    assign bus.H_write   = h_write_q;
    assign bus.H_data    = h_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hit_ready = hit_ready_q;

endmodule

// File: tb/tb_hive_damage_writer.sv
// Self-checking bench for hive_damage_writer: directed hits plus random hits and wr_allow,
// scored cycle by cycle against a crater model built from hive-local pixel arithmetic.
module tb_hive_damage_writer;

    localparam int         HIVE_W = 56;
    localparam int         HIVE_H = 39;
    localparam int         CW     = 4;
    localparam int         CH     = 4;
    localparam int         NPOS   = CW * CH;
    localparam logic [7:0] TRANSP = 8'h00;

    logic clk_pix = 1'b0;
    logic reset;

    hive_damage_writer_if bus ();

    hive_damage_writer dut (
        .clk_pix (clk_pix),
        .reset   (reset),
        .bus     (bus)
    );

    always #20 clk_pix = ~clk_pix;

    int checks = 0;
    int passed = 0;

    // Expected outcome per crater position, in raster order.
    bit          exp_wr   [NPOS];
    int          exp_addr [NPOS];
    int          exp_count;
    int          wr_log[$];
    logic [15:0] model_lfsr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

`ifdef HIVE_DMG_RAGGED_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction
`endif

    function automatic void build_model(input int hx, input int hy);
        int px, py, i;
        bit inr;
        exp_count = 0;
        for (int cy = 0; cy < CH; cy++) begin
            for (int cx = 0; cx < CW; cx++) begin
                i   = cy * CW + cx;
                px  = hx - CW / 2 + cx;
                py  = hy - CH / 2 + cy;
                inr = (px >= 0) && (px < HIVE_W) && (py >= 0) && (py < HIVE_H);
`ifdef HIVE_DMG_RAGGED_EN
                exp_wr[i]  = inr && (model_lfsr[0] || (px == hx && py == hy));
                model_lfsr = lfsr_step(model_lfsr);
`else
                exp_wr[i]  = inr;
`endif
                exp_addr[i] = py * HIVE_W + px;
                if (exp_wr[i]) exp_count++;
            end
        end
    endfunction

    // mode: 0 = wr_allow always 1, 1 = random, 2 = pause of 10 cycles once pause_at positions
    // are consumed. abort_at >= 0 asserts reset once that many positions are consumed.
    task automatic run_hit(input string name, input int hx, input int hy, input int mode,
                           input int pause_at, input int abort_at);
        int consumed, cyc, pause_left, max_addr, found, dones;
        bit allow, in_range;
        wr_log.delete();
        in_range = (hx < HIVE_W) && (hy < HIVE_H);
        cyc = 0;
        while (bus.hit_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk_pix);
            cyc++;
        end
        check({name, " ready_before"}, bus.hit_ready, 1);
        if (in_range) build_model(hx, hy);
        else exp_count = 0;

        bus.hit_valid = 1'b1;
        bus.hit_x     = 6'(hx);
        bus.hit_y     = 6'(hy);
        bus.wr_allow  = 1'($urandom);
        @(negedge clk_pix);
        bus.hit_valid = 1'b0;
        bus.hit_x     = 6'($urandom);
        bus.hit_y     = 6'($urandom);
        check({name, " ready_after_accept"}, bus.hit_ready, 0);
        check({name, " busy_after_accept"}, bus.busy, 1);
        check({name, " write_after_accept"}, bus.H_write, 0);

        if (in_range) begin
            consumed   = 0;
            pause_left = 10;
            cyc        = 0;
            while (consumed < NPOS && cyc < 400) begin
                if (mode == 2 && consumed == pause_at && pause_left > 0) begin
                    allow = 1'b0;
                    pause_left--;
                end else if (mode == 1) begin
                    allow = ($urandom_range(0, 3) != 0);
                end else begin
                    allow = 1'b1;
                end
                bus.wr_allow = allow;
                @(negedge clk_pix);
                cyc++;
                if (bus.H_write === 1'b1) wr_log.push_back(int'(bus.H_address));
                if (allow) begin
                    check({name, " write_strobe"}, bus.H_write, exp_wr[consumed]);
                    if (exp_wr[consumed]) begin
                        check({name, " address"}, bus.H_address, exp_addr[consumed]);
                        check({name, " data"}, bus.H_data, TRANSP);
                    end
                    consumed++;
                end else begin
                    check({name, " paused_write"}, bus.H_write, 0);
                end
                check({name, " done_during_scan"}, bus.done, 0);
                if (consumed == abort_at) begin
                    reset = 1'b1;
                    @(negedge clk_pix);
                    reset = 1'b0;
                    model_lfsr = 16'hACE1;
                    check({name, " abort_write"}, bus.H_write, 0);
                    check({name, " abort_busy"}, bus.busy, 0);
                    check({name, " abort_ready"}, bus.hit_ready, 1);
                    dones = 0;
                    for (int k = 0; k < 20; k++) begin
                        bus.wr_allow = 1'b1;
                        if (bus.done === 1'b1 || bus.H_write === 1'b1) dones++;
                        @(negedge clk_pix);
                    end
                    check({name, " abort_no_done_or_write"}, dones, 0);
                    return;
                end
            end
            check({name, " positions_consumed"}, consumed, NPOS);
        end

        bus.wr_allow = 1'($urandom);
        @(negedge clk_pix);
        check({name, " done_pulse"}, bus.done, 1);
        check({name, " busy_with_done"}, bus.busy, 1);
        check({name, " write_with_done"}, bus.H_write, 0);
        @(negedge clk_pix);
        check({name, " done_cleared"}, bus.done, 0);
        check({name, " busy_cleared"}, bus.busy, 0);
        check({name, " ready_again"}, bus.hit_ready, 1);
        check({name, " write_count"}, wr_log.size(), exp_count);

        max_addr = 0;
        foreach (wr_log[k]) if (wr_log[k] > max_addr) max_addr = wr_log[k];
        check({name, " max_addr_in_ram"}, (max_addr < HIVE_W * HIVE_H), 1);
`ifdef HIVE_DMG_RAGGED_EN
        if (in_range) begin
            found = 0;
            foreach (wr_log[k]) if (wr_log[k] == hy * HIVE_W + hx) found = 1;
            check({name, " centre_written"}, found, 1);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.hit_valid = 1'b0;
        bus.hit_x     = '0;
        bus.hit_y     = '0;
        bus.wr_allow  = 1'b0;
        model_lfsr    = 16'hACE1;
        repeat (3) @(negedge clk_pix);
        check("reset H_address", bus.H_address, 0);
        check("reset H_write", bus.H_write, 0);
        check("reset H_data", bus.H_data, TRANSP);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset hit_ready", bus.hit_ready, 1);
        reset = 1'b0;
        @(negedge clk_pix);

        run_hit("t1_centre", 20, 10, 0, -1, -1);
`ifndef HIVE_DMG_RAGGED_EN
        check("t1 first_addr", wr_log[0], 466);
        check("t1 row2_addr", wr_log[4], 522);
        check("t1 last_addr", wr_log[15], 637);
`endif

        run_hit("t2_corner00", 0, 0, 0, -1, -1);
`ifndef HIVE_DMG_RAGGED_EN
        check("t2 addr0", wr_log[0], 0);
        check("t2 addr1", wr_log[1], 1);
        check("t2 addr2", wr_log[2], 56);
        check("t2 addr3", wr_log[3], 57);
`endif

        run_hit("t3_corner_far", 55, 38, 1, -1, -1);
`ifndef HIVE_DMG_RAGGED_EN
        check("t3 last_addr", wr_log[wr_log.size() - 1], 2183);
`endif

        run_hit("t4_pause", 20, 10, 2, 5, -1);
`ifndef HIVE_DMG_RAGGED_EN
        check("t4 sixth_addr", wr_log[5], 523);
`endif

        run_hit("t5_out_x", 60, 5, 0, -1, -1);
        run_hit("t5_out_y", 10, 45, 1, -1, -1);

        run_hit("t6_abort", 20, 10, 0, -1, 7);
        run_hit("t6_after_abort", 30, 20, 1, -1, -1);

        for (int n = 0; n < 12; n++) begin
            run_hit("rand", int'($urandom_range(0, 63)), int'($urandom_range(0, 47)), 1, -1, -1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
